// File: rtl/ping_pong_buffer.sv
// Ping-pong buffer between a JTAG port and a DMA engine.
// One storage array is split into two banks. The JTAG side owns bank
// bank_sel and the DMA side owns the other bank. A handshake swaps the
// two owners, and the block-size words are exchanged at the same time.
module ping_pong_buffer #(
    parameter int BANK_AW = 8
) (
    input  logic               clock,
    input  logic               n_reset,
    input  logic [BANK_AW-1:0] j_address,
    input  logic [31:0]        j_dataIn,
    input  logic               j_writeEnable,
    output logic [31:0]        j_dataOut,
    input  logic               j_swap,
    input  logic [7:0]         j_block_sizeIN,
    output logic [7:0]         j_block_sizeOUT,
    input  logic [BANK_AW:0]   pp_address,
    input  logic [31:0]        pp_dataIn,
    input  logic               pp_writeEnable,
    output logic [31:0]        pp_dataOut,
    input  logic               dma_busy,
    input  logic [7:0]         dma_block_sizeIN,
    output logic [7:0]         dma_block_sizeOUT,
    output logic               bank_sel,
    output logic               swap_pending,
    output logic               swap_done,
    output logic               addr_error
);

    localparam int TOTAL_WORDS = 2 * (1 << BANK_AW);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PENDING = 2'd1;
    localparam logic [1:0] ST_SWAP    = 2'd2;

    logic [31:0]      r_mem [0:TOTAL_WORDS-1];
    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic             w_do_swap;
    logic             r_bank_sel;
    logic             r_swap_done;
    logic             r_addr_error;
    logic [31:0]      r_j_data_out;
    logic [31:0]      r_pp_data_out;
    logic [7:0]       r_j_block_size_out;
    logic [7:0]       r_dma_block_size_out;
    logic             w_pp_out_of_range;
    logic [BANK_AW:0] w_j_index;
    logic [BANK_AW:0] w_pp_index;

    // Any DMA address with the top bit set lies outside the DMA-owned bank.
    assign w_pp_out_of_range = pp_address[BANK_AW];
    assign w_j_index         = {r_bank_sel, j_address};
    assign w_pp_index        = {~r_bank_sel, pp_address[BANK_AW-1:0]};

    // Storage writes from both sides. The banks are disjoint, so the two ports never collide.
    // NOTE: the storage array has no reset on purpose. Clearing it would need
    // a per-word reset network, and its contents must survive a reset anyway.
    // Reset only blocks the write strobes.
    always_ff @(posedge clock) begin
        if (n_reset) begin
            if (j_writeEnable) begin
                // NOTE: non-blocking assignment, so that same-edge reads below
                // see the old word (read-first behaviour).
                r_mem[w_j_index] <= j_dataIn;
            end
            if (pp_writeEnable && !w_pp_out_of_range) begin
                r_mem[w_pp_index] <= pp_dataIn;
            end
        end
    end

    // Registered read ports with one-cycle latency. An out-of-range DMA access returns zero and raises the error flag.
    always_ff @(posedge clock) begin
        if (!n_reset) begin
            r_j_data_out  <= '0;
            r_pp_data_out <= '0;
            r_addr_error  <= 1'b0;
        end else begin
            r_j_data_out  <= r_mem[w_j_index];
            r_pp_data_out <= w_pp_out_of_range ? 32'd0 : r_mem[w_pp_index];
            r_addr_error  <= w_pp_out_of_range;
        end
    end

    // Swap FSM next-state logic. A request made while in PENDING or SWAP is dropped.
    always_comb begin
        // NOTE: assign defaults first so that no path through the case leaves
        // a signal unassigned, which would infer a latch.
        w_next_state = r_state;
        w_do_swap    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (j_swap) begin
                    if (dma_busy) begin
                        w_next_state = ST_PENDING;
                    end else begin
                        w_next_state = ST_SWAP;
                        w_do_swap    = 1'b1;
                    end
                end
            end
            ST_PENDING: begin
                if (!dma_busy) begin
                    w_next_state = ST_SWAP;
                    w_do_swap    = 1'b1;
                end
            end
            ST_SWAP: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Swap FSM state, bank ownership and the block-size exchange.
    always_ff @(posedge clock) begin
        if (!n_reset) begin
            r_state              <= ST_IDLE;
            r_bank_sel           <= 1'b0;
            r_swap_done          <= 1'b0;
            r_j_block_size_out   <= '0;
            r_dma_block_size_out <= '0;
        end else begin
            r_state     <= w_next_state;
            r_swap_done <= w_do_swap;
            if (w_do_swap) begin
                r_bank_sel           <= ~r_bank_sel;
                r_dma_block_size_out <= j_block_sizeIN;
                r_j_block_size_out   <= dma_block_sizeIN;
            end
        end
    end

    assign j_dataOut         = r_j_data_out;
    assign pp_dataOut        = r_pp_data_out;
    assign addr_error        = r_addr_error;
    assign bank_sel          = r_bank_sel;
    assign swap_done         = r_swap_done;
    assign swap_pending      = (r_state == ST_PENDING);
    assign j_block_sizeOUT   = r_j_block_size_out;
    assign dma_block_sizeOUT = r_dma_block_size_out;

endmodule

// File: tb/tb_ping_pong_buffer.sv
// Self-checking bench for ping_pong_buffer.
// It runs directed scenarios, then a random phase, then a full read-back
// sweep. The reference model below treats the buffer as two banks with
// an owner bit and a pending-request flag.
module tb_ping_pong_buffer;

    localparam int AW = 8;
    localparam int BW = 1 << AW;

    logic          clock;
    logic          n_reset;
    logic [AW-1:0] j_address;
    logic [31:0]   j_dataIn;
    logic          j_writeEnable;
    logic [31:0]   j_dataOut;
    logic          j_swap;
    logic [7:0]    j_block_sizeIN;
    logic [7:0]    j_block_sizeOUT;
    logic [AW:0]   pp_address;
    logic [31:0]   pp_dataIn;
    logic          pp_writeEnable;
    logic [31:0]   pp_dataOut;
    logic          dma_busy;
    logic [7:0]    dma_block_sizeIN;
    logic [7:0]    dma_block_sizeOUT;
    logic          bank_sel;
    logic          swap_pending;
    logic          swap_done;
    logic          addr_error;

    ping_pong_buffer #(.BANK_AW(AW)) dut (
        .clock             (clock),
        .n_reset           (n_reset),
        .j_address         (j_address),
        .j_dataIn          (j_dataIn),
        .j_writeEnable     (j_writeEnable),
        .j_dataOut         (j_dataOut),
        .j_swap            (j_swap),
        .j_block_sizeIN    (j_block_sizeIN),
        .j_block_sizeOUT   (j_block_sizeOUT),
        .pp_address        (pp_address),
        .pp_dataIn         (pp_dataIn),
        .pp_writeEnable    (pp_writeEnable),
        .pp_dataOut        (pp_dataOut),
        .dma_busy          (dma_busy),
        .dma_block_sizeIN  (dma_block_sizeIN),
        .dma_block_sizeOUT (dma_block_sizeOUT),
        .bank_sel          (bank_sel),
        .swap_pending      (swap_pending),
        .swap_done         (swap_done),
        .addr_error        (addr_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state.
    logic [31:0] m_mem [0:2*BW-1];
    bit          m_known [0:2*BW-1];
    bit          m_bank;
    bit          m_pending;
    bit          m_in_swap;
    logic [7:0]  m_j_bso;
    logic [7:0]  m_dma_bso;

    // Values expected after the next edge.
    logic [31:0] e_jout;
    logic [31:0] e_ppout;
    bit          e_jout_known;
    bit          e_ppout_known;
    bit          e_aerr;
    bit          e_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_quiet();
        n_reset          = 1'b1;
        j_address        = '0;
        j_dataIn         = '0;
        j_writeEnable    = 1'b0;
        j_swap           = 1'b0;
        j_block_sizeIN   = '0;
        pp_address       = '0;
        pp_dataIn        = '0;
        pp_writeEnable   = 1'b0;
        dma_busy         = 1'b0;
        dma_block_sizeIN = '0;
    endtask

    // Apply one clock edge. First predict the result from the current
    // inputs and the model, then let the edge happen and compare.
    task automatic step();
        int  ji;
        int  pi;
        bit  oor;
        bit  wants;
        oor = pp_address[AW];
        ji  = (m_bank ? BW : 0) + int'(j_address);
        pi  = (m_bank ? 0 : BW) + int'(pp_address[AW-1:0]);
        if (!n_reset) begin
            e_jout = 0; e_jout_known = 1;
            e_ppout = 0; e_ppout_known = 1;
            e_aerr = 0; e_done = 0;
            m_bank = 0; m_pending = 0; m_in_swap = 0;
            m_j_bso = 0; m_dma_bso = 0;
        end else begin
            e_jout        = m_mem[ji];
            e_jout_known  = m_known[ji];
            e_ppout       = oor ? 32'd0 : m_mem[pi];
            e_ppout_known = oor ? 1'b1 : m_known[pi];
            e_aerr        = oor;
            if (j_writeEnable) begin
                m_mem[ji] = j_dataIn; m_known[ji] = 1;
            end
            if (pp_writeEnable && !oor) begin
                m_mem[pi] = pp_dataIn; m_known[pi] = 1;
            end
            // A request is live if one is waiting, or a new one arrives
            // while no swap is in progress.
            wants     = !m_in_swap && (m_pending || j_swap);
            e_done    = wants && !dma_busy;
            m_pending = wants && dma_busy;
            m_in_swap = e_done;
            if (e_done) begin
                m_bank    = !m_bank;
                m_dma_bso = j_block_sizeIN;
                m_j_bso   = dma_block_sizeIN;
            end
        end
        @(posedge clock);
        #1;
        if (e_jout_known) chk("j_dataOut", j_dataOut, e_jout);
        if (e_ppout_known) chk("pp_dataOut", pp_dataOut, e_ppout);
        chk("bank_sel", 32'(bank_sel), 32'(m_bank));
        chk("swap_pending", 32'(swap_pending), 32'(m_pending));
        chk("swap_done", 32'(swap_done), 32'(e_done));
        chk("addr_error", 32'(addr_error), 32'(e_aerr));
        chk("j_block_sizeOUT", 32'(j_block_sizeOUT), 32'(m_j_bso));
        chk("dma_block_sizeOUT", 32'(dma_block_sizeOUT), 32'(m_dma_bso));
    endtask

    initial begin
        for (int i = 0; i < 2*BW; i++) begin
            m_mem[i] = '0; m_known[i] = 0;
        end
        m_bank = 0; m_pending = 0; m_in_swap = 0; m_j_bso = 0; m_dma_bso = 0;

        // Reset state.
        set_quiet();
        n_reset = 1'b0;
        step();
        step();
        chk("reset_bank_sel", 32'(bank_sel), 32'd0);
        chk("reset_j_dataOut", j_dataOut, 32'd0);
        n_reset = 1'b1;

        // Fill both banks with random data.
        for (int i = 0; i < BW; i++) begin
            j_address      = AW'(i);
            j_dataIn       = $urandom;
            j_writeEnable  = 1'b1;
            pp_address     = (AW+1)'(i);
            pp_dataIn      = $urandom;
            pp_writeEnable = 1'b1;
            step();
        end
        set_quiet();

        // Basic swap handing four words to the DMA side.
        for (int i = 0; i < 4; i++) begin
            j_address     = AW'(i);
            j_dataIn      = 32'h11 + 32'(i);
            j_writeEnable = 1'b1;
            step();
        end
        set_quiet();
        j_block_sizeIN = 8'd4;
        j_swap         = 1'b1;
        step();
        chk("basic_swap_done", 32'(swap_done), 32'd1);
        chk("basic_bank_sel", 32'(bank_sel), 32'd1);
        chk("basic_dma_bso", 32'(dma_block_sizeOUT), 32'd4);
        j_swap     = 1'b0;
        pp_address = 9'd2;
        step();
        chk("basic_dma_read2", pp_dataOut, 32'h13);
        set_quiet();
        step();

        // Swap held off by a busy DMA for five cycles.
        j_swap   = 1'b1;
        dma_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            j_swap = 1'b0;
            chk("busy_pending", 32'(swap_pending), 32'd1);
            chk("busy_bank_hold", 32'(bank_sel), 32'd1);
        end
        dma_busy = 1'b0;
        step();
        chk("busy_release_done", 32'(swap_done), 32'd1);
        chk("busy_release_bank", 32'(bank_sel), 32'd0);
        step();

        // Simultaneous writes to the same offset in both banks.
        j_address = AW'(5); j_dataIn = 32'hAA; j_writeEnable = 1'b1;
        pp_address = 9'd5; pp_dataIn = 32'hBB; pp_writeEnable = 1'b1;
        step();
        set_quiet();
        j_address = AW'(5); pp_address = 9'd5;
        step();
        chk("simul_j_read5", j_dataOut, 32'hAA);
        j_swap = 1'b1;
        step();
        j_swap = 1'b0;
        step();
        chk("simul_swapped_j5", j_dataOut, 32'hBB);
        chk("simul_swapped_dma5", pp_dataOut, 32'hAA);
        step();

        // Out-of-range DMA write.
        set_quiet();
        pp_address = 9'h100; pp_dataIn = 32'hDEADBEEF; pp_writeEnable = 1'b1;
        step();
        chk("oor_addr_error", 32'(addr_error), 32'd1);
        chk("oor_pp_dataOut", pp_dataOut, 32'd0);
        set_quiet();
        step();
        chk("oor_error_clears", 32'(addr_error), 32'd0);

        // Reset while a swap is pending.
        j_swap = 1'b1; dma_busy = 1'b1;
        step();
        j_swap = 1'b0;
        step();
        n_reset = 1'b0;
        step();
        chk("rst_pend_pending", 32'(swap_pending), 32'd0);
        chk("rst_pend_bank", 32'(bank_sel), 32'd0);
        set_quiet();
        j_address = AW'(5);
        step();
        chk("rst_pend_no_swap", 32'(swap_done), 32'd0);
        chk("rst_pend_data", j_dataOut, 32'hAA);

        // Block size reported by the DMA.
        set_quiet();
        dma_block_sizeIN = 8'd7; j_swap = 1'b1;
        step();
        chk("bsize_done", 32'(swap_done), 32'd1);
        chk("bsize_j_out", 32'(j_block_sizeOUT), 32'd7);
        set_quiet();
        step();
        chk("bsize_j_out_hold", 32'(j_block_sizeOUT), 32'd7);

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            n_reset          = ($urandom_range(63) != 0);
            j_address        = AW'($urandom_range(7));
            j_dataIn         = $urandom;
            j_writeEnable    = $urandom_range(1) == 1;
            j_swap           = $urandom_range(3) == 0;
            j_block_sizeIN   = 8'($urandom);
            pp_address       = ($urandom_range(15) == 0) ? {1'b1, AW'($urandom)}
                                                         : {1'b0, AW'($urandom_range(7))};
            pp_dataIn        = $urandom;
            pp_writeEnable   = $urandom_range(1) == 1;
            dma_busy         = $urandom_range(1) == 1;
            dma_block_sizeIN = 8'($urandom);
            step();
        end

        // Read back every word through both ports.
        set_quiet();
        for (int i = 0; i < BW; i++) begin
            j_address  = AW'(i);
            pp_address = (AW+1)'(i);
            step();
        end
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
